// File: rtl/bus_arbiter_2m.sv
// ---------------------------------------------------------------------------
// bus_arbiter_2m
// Two-master bus arbiter with a one-cycle turnaround between owners and a
// hold limit that revokes an owner that keeps the bus while the other master
// is waiting.
//
// Parameters
//   MAX_HOLD     maximum consecutive contended owner cycles (2..255)
// Ports
//   clk          system clock, rising edge
//   rstn         asynchronous active-low reset
//   breq_0/1     bus requests from master 0 / master 1
//   bgnt_0/1     bus grants to master 0 / master 1 (registered)
//   sel          ADDR/control mux select: 01 = master 0, 10 = master 1, 00 = idle
//   bus_busy     high while either master owns the bus
//   timeout_err  one-cycle pulse when an owner is revoked at the hold limit
// ---------------------------------------------------------------------------
module bus_arbiter_2m #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       breq_0,
  input  logic       breq_1,
  output logic       bgnt_0,
  output logic       bgnt_1,
  output logic [1:0] sel,
  output logic       bus_busy,
  output logic       timeout_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2,
    TURN = 2'd3
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t     state;
  logic       last_owner;
  logic [7:0] hold_cnt;

  state_t     nxt_state;
  logic       nxt_last;
  logic [7:0] nxt_cnt;
  logic       nxt_timeout;

  // Tie goes to the master that did not own the bus last.
  function automatic state_t arbitrate(input logic r0, input logic r1,
                                       input logic lo);
    state_t s;
    if (r0 && r1)  s = lo ? OWN0 : OWN1;
    else if (r0)   s = OWN0;
    else if (r1)   s = OWN1;
    else           s = IDLE;
    return s;
  endfunction

  always_comb begin
    nxt_state   = state;
    nxt_last    = last_owner;
    nxt_cnt     = hold_cnt;
    nxt_timeout = 1'b0;
    unique case (state)
      IDLE, TURN: begin
        nxt_state = arbitrate(breq_0, breq_1, last_owner);
        nxt_cnt   = '0;
      end
      OWN0: begin
        // A release at the same edge as the limit is a plain release.
        if (!breq_0) begin
          nxt_state = TURN;
          nxt_last  = 1'b0;
        end else if (breq_1) begin
          if (hold_cnt == HOLD_LAST) begin
            nxt_state   = TURN;
            nxt_last    = 1'b0;
            nxt_timeout = 1'b1;
          end else begin
            nxt_cnt = hold_cnt + 8'd1;
          end
        end
      end
      OWN1: begin
        if (!breq_1) begin
          nxt_state = TURN;
          nxt_last  = 1'b1;
        end else if (breq_0) begin
          if (hold_cnt == HOLD_LAST) begin
            nxt_state   = TURN;
            nxt_last    = 1'b1;
            nxt_timeout = 1'b1;
          end else begin
            nxt_cnt = hold_cnt + 8'd1;
          end
        end
      end
    endcase
  end

  // Outputs are registered from the next state so they track the state
  // register exactly, with no path from the requests to any output.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      last_owner  <= 1'b1;
      hold_cnt    <= '0;
      bgnt_0      <= 1'b0;
      bgnt_1      <= 1'b0;
      sel         <= 2'b00;
      bus_busy    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= nxt_state;
      last_owner  <= nxt_last;
      hold_cnt    <= nxt_cnt;
      bgnt_0      <= (nxt_state == OWN0);
      bgnt_1      <= (nxt_state == OWN1);
      sel         <= {nxt_state == OWN1, nxt_state == OWN0};
      bus_busy    <= (nxt_state == OWN0) || (nxt_state == OWN1);
      timeout_err <= nxt_timeout;
    end
  end

endmodule

// File: tb/tb_bus_arbiter_2m.sv
// ---------------------------------------------------------------------------
// tb_bus_arbiter_2m
// Self-checking bench for bus_arbiter_2m (MAX_HOLD = 4). A behavioural
// owner/turnaround model predicts the outputs after every rising edge.
// ---------------------------------------------------------------------------
module tb_bus_arbiter_2m;

  localparam int MAX_HOLD = 4;

  logic       clk;
  logic       rstn;
  logic       breq_0;
  logic       breq_1;
  logic       bgnt_0;
  logic       bgnt_1;
  logic [1:0] sel;
  logic       bus_busy;
  logic       timeout_err;

  bus_arbiter_2m #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .breq_0      (breq_0),
    .breq_1      (breq_1),
    .bgnt_0      (bgnt_0),
    .bgnt_1      (bgnt_1),
    .sel         (sel),
    .bus_busy    (bus_busy),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: who owns the bus (-1 = nobody), who owned it last,
  // how many contended edges the current owner has survived.
  int m_owner;
  int m_last;
  int m_cont;
  bit m_to;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_last  = 1;
    m_cont  = 0;
    m_to    = 1'b0;
  endtask

  task automatic model_edge(input bit b0, input bit b1);
    bit mine, other;
    m_to = 1'b0;
    if (m_owner < 0) begin
      if (b0 && b1)  m_owner = (m_last == 0) ? 1 : 0;
      else if (b0)   m_owner = 0;
      else if (b1)   m_owner = 1;
      m_cont = 0;
    end else begin
      mine  = (m_owner == 0) ? b0 : b1;
      other = (m_owner == 0) ? b1 : b0;
      if (!mine) begin
        m_last  = m_owner;
        m_owner = -1;
      end else if (other) begin
        m_cont++;
        if (m_cont == MAX_HOLD) begin
          m_to    = 1'b1;
          m_last  = m_owner;
          m_owner = -1;
        end
      end
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_gnt"},  int'({bgnt_1, bgnt_0}),
        (m_owner == 1) ? 2 : (m_owner == 0) ? 1 : 0);
    chk({tag, "_sel"},  int'(sel), (m_owner == 1) ? 2 : (m_owner == 0) ? 1 : 0);
    chk({tag, "_busy"}, int'(bus_busy), (m_owner >= 0) ? 1 : 0);
    chk({tag, "_to"},   int'(timeout_err), int'(m_to));
  endtask

  // Drive requests at the falling edge, advance the model at the rising
  // edge, compare 1 time unit later.
  task automatic step(input bit b0, input bit b1, input string tag);
    @(negedge clk);
    breq_0 = b0;
    breq_1 = b1;
    @(posedge clk);
    model_edge(b0, b1);
    #1;
    check_model(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn   = 1'b0;
    breq_0 = 1'b0;
    breq_1 = 1'b0;
    model_reset();
    #1;
    check_model("rst");
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    bit b0, b1, pg0, pg1;
    rstn   = 1'b0;
    breq_0 = 1'b0;
    breq_1 = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gnt0", int'(bgnt_0), 0);
    chk("rst_gnt1", int'(bgnt_1), 0);
    chk("rst_sel",  int'(sel), 0);
    chk("rst_busy", int'(bus_busy), 0);
    chk("rst_to",   int'(timeout_err), 0);
    @(negedge clk);
    rstn = 1'b1;

    // Lone master 0: grant after one edge, release through TURN to IDLE,
    // re-request only regranted after the gap.
    step(1, 0, "solo0_e1");
    chk("solo0_sel01", int'(sel), 1);
    step(1, 0, "solo0_e2");
    step(1, 0, "solo0_e3");
    step(1, 0, "solo0_e4");
    step(0, 0, "solo0_rel");
    chk("solo0_turn_sel", int'(sel), 0);
    step(1, 0, "solo0_rereq");
    chk("solo0_regnt", int'(bgnt_0), 1);
    step(0, 0, "solo0_rel2");
    step(0, 0, "solo0_idle");

    // Tie from reset: master 0 first, then master 1 after a TURN.
    do_reset();
    step(1, 1, "tie_e1");
    chk("tie_own0", int'(bgnt_0), 1);
    step(1, 1, "tie_e2");
    step(0, 1, "tie_rel");
    chk("tie_turn_sel", int'(sel), 0);
    step(0, 1, "tie_own1");
    chk("tie_sel10", int'(sel), 2);

    // Hold limit: master 0 revoked after 4 contended cycles.
    do_reset();
    step(1, 1, "to_entry");
    for (int i = 0; i < MAX_HOLD - 1; i++) step(1, 1, "to_hold");
    chk("to_not_yet", int'(timeout_err), 0);
    step(1, 1, "to_fire");
    chk("to_pulse", int'(timeout_err), 1);
    chk("to_turn_sel", int'(sel), 0);
    step(1, 1, "to_own1");
    chk("to_own1_sel", int'(sel), 2);
    chk("to_pulse_end", int'(timeout_err), 0);
    // Release at the same edge the limit would fire: plain release.
    for (int i = 0; i < MAX_HOLD - 1; i++) step(1, 1, "to_own1_hold");
    step(1, 0, "to_rel_same");
    chk("to_rel_no_err", int'(timeout_err), 0);
    step(1, 0, "to_after_rel");

    // Sub-cycle glitch on breq_0 between edges is ignored.
    step(0, 0, "gl_idle");
    #1 breq_0 = 1'b1;
    #2 breq_0 = 1'b0;
    step(0, 0, "gl_check");
    chk("gl_no_gnt", int'(bgnt_0), 0);

    // Lone master 1 for 300 cycles: never times out.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      step(0, 1, "solo1");
      chk("solo1_steady", int'(bgnt_1), 1);
    end

    // Asynchronous reset mid-OWN1, then restart with both requesting.
    #2 rstn = 1'b0;
    model_reset();
    #1;
    chk("areset_gnt1", int'(bgnt_1), 0);
    chk("areset_sel", int'(sel), 0);
    @(negedge clk);
    rstn   = 1'b1;
    breq_0 = 1'b1;
    breq_1 = 1'b1;
    @(posedge clk);
    model_edge(1, 1);
    #1;
    check_model("areset_rel");
    chk("areset_own0", int'(bgnt_0), 1);

    // Random request traffic with structural checks alongside the model.
    b0 = 1'b1;
    b1 = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(7) == 0) b0 = ~b0;
      if ($urandom_range(7) == 0) b1 = ~b1;
      pg0 = bgnt_0;
      pg1 = bgnt_1;
      step(b0, b1, "rnd");
      chk("rnd_excl", int'(bgnt_0 & bgnt_1), 0);
      chk("rnd_sel11", int'(sel == 2'b11), 0);
      chk("rnd_via_turn", int'((pg0 & bgnt_1) | (pg1 & bgnt_0)), 0);
      if (!pg0 && bgnt_0) chk("rnd_req0", int'(b0), 1);
      if (!pg1 && bgnt_1) chk("rnd_req1", int'(b1), 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_arbiter_2m.md
BUS_ARBITER_2M -- requirements
Module: bus_arbiter_2m

Interface
REQ-001 Parameter: MAX_HOLD, default 16, the maximum number of consecutive owner cycles allowed while the other master is waiting (legal range 2..255).
REQ-002 Port: clk  input  1  the single system clock; all state changes on its rising edge.
REQ-003 Port: rstn  input  1  reset, asynchronous and active-low.
REQ-004 Port: breq_0  input  1  bus request from master 0; held high for the whole transfer.
REQ-005 Port: breq_1  input  1  bus request from master 1; held high for the whole transfer.
REQ-006 Port: bgnt_0  output  1  bus grant to master 0.
REQ-007 Port: bgnt_1  output  1  bus grant to master 1.
REQ-008 Port: sel  output  2  select for the 14-bit ADDR/control 2:1 mux: 2'b01 routes master 0 (in_0), 2'b10 routes master 1 (in_1), 2'b00 means idle.
REQ-009 Port: bus_busy  output  1  high while either master owns the bus.
REQ-010 Port: timeout_err  output  1  one-cycle pulse when an owner is revoked for exceeding MAX_HOLD.

Function
REQ-011 The FSM SHALL have states IDLE, OWN0, OWN1 and TURN, encoded in registers.
REQ-012 All outputs SHALL be registered or decoded from state registers only, with no combinational path from breq_x to any output.
REQ-013 Decode: OWN0 -> bgnt_0=1, sel=01; OWN1 -> bgnt_1=1, sel=10; IDLE/TURN -> both grants 0, sel=00; bus_busy = OWN0|OWN1.
REQ-014 bgnt_0 and bgnt_1 SHALL never be high in the same cycle, and sel SHALL never be 2'b11.
REQ-015 Arbitration in IDLE or TURN: only breq_0 high -> OWN0; only breq_1 high -> OWN1; both high -> the master other than last_owner; neither -> IDLE.
REQ-016 Grant latency SHALL be one cycle: a request sampled high at edge k in IDLE/TURN sets the grant after edge k.
REQ-017 last_owner SHALL be a 1-bit register updated to x on every exit from OWNx; its reset value is 1, so master 0 wins the first tie.
REQ-018 OWNx SHALL be held while breq_x is high and the hold limit is not reached.
REQ-019 breq_x sampled low in OWNx -> TURN, and the grant drops at that edge.
REQ-020 hold_cnt (8-bit) SHALL clear on entry to OWNx, increment each OWNx cycle in which the other breq is high, and hold otherwise.
REQ-021 When hold_cnt == MAX_HOLD-1 and the other breq is high at an edge, the arbiter SHALL go OWNx -> TURN and pulse timeout_err for exactly one cycle.
REQ-022 TURN SHALL last exactly one cycle with no grant (bus turnaround), then arbitrate per REQ-015.
REQ-023 A revoked master that keeps breq high SHALL lose the next tie, since last_owner = x.
REQ-024 A lone owner with no competing request SHALL never time out, and hold_cnt SHALL not wrap.
REQ-025 A breq deassert and a timeout at the same edge SHALL resolve as a normal release: TURN with no timeout_err.
REQ-026 A breq pulse shorter than one cycle that is not sampled at an edge SHALL be ignored.
REQ-027 An owner re-requesting after its release SHALL be regranted only via TURN, never back-to-back without a gap.

Reset
REQ-028 rstn low SHALL immediately, without waiting for clk, force IDLE, bgnt_0=0, bgnt_1=0, sel=00, bus_busy=0, timeout_err=0, hold_cnt=0 and last_owner=1.
REQ-029 Reset asserted mid-transfer SHALL drop the grant immediately, and after reset release arbitration SHALL restart from IDLE on the next edge.

Verification
REQ-030 Bench: breq_0=1 alone at edge 1 -> bgnt_0=1 and sel=01 after edge 1; breq_0=0 at edge 5 -> TURN (sel=00), then IDLE.
REQ-031 Bench: breq_0 and breq_1 high together from reset -> OWN0 first; on breq_0 release -> TURN for 1 cycle, then OWN1 (sel=10).
REQ-032 Bench: MAX_HOLD=4, master 0 owns with breq_1 held high -> after 4 contended OWN0 cycles timeout_err pulses one cycle, TURN follows, then OWN1, even though breq_0 is still high.
REQ-033 Bench: master 1 owns alone for 300 cycles -> no timeout_err and grant steady.
REQ-034 Bench: rstn pulled low asynchronously mid-OWN1 -> bgnt_1=0 and sel=00 before the next clk edge; after release with both requests high -> OWN0 granted.
REQ-035 Bench: random breq traffic for 10k cycles -> REQ-014 holds, every grant is preceded by its request, and every exit from an OWN state passes through TURN.
